// File: rtl/s2p_seq_ctrl.sv
// rtl/s2p_seq_ctrl.sv - sequencer driving MODO/ENB/DIR of an 8-bit serial/parallel shift register
// Accepts one TX/RX/ROT/LDONLY command per START and enables the register for exactly the needed edges.
module s2p_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       START,
   input  logic [1:0] OP,
   input  logic       DIR_IN,
   input  logic [2:0] ROT_N,
   input  logic       HOLD,
   output logic [1:0] REG_MODO,
   output logic       REG_ENB,
   output logic       REG_DIR,
   output logic       BUSY,
   output logic       DONE
);

   localparam logic [1:0] MODO_PUSH  = 2'b00;
   localparam logic [1:0] MODO_CYCLE = 2'b01;
   localparam logic [1:0] MODO_LOAD  = 2'b10;

   localparam logic [1:0] OP_TX  = 2'b00;
   localparam logic [1:0] OP_RX  = 2'b01;
   localparam logic [1:0] OP_ROT = 2'b10;
   localparam logic [1:0] OP_LD  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_SHIFT = 3'd2,
      S_ROT   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic               dir_q, dir_d;
   logic [2:0]         n_q, n_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      dir_d   = dir_q;
      n_d     = n_q;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               op_d  = OP;
               dir_d = DIR_IN;
               n_d   = ROT_N;
               cnt_d = '0;
               case (OP)
                  OP_TX, OP_LD: state_d = S_LOAD;
                  OP_RX:        state_d = S_SHIFT;
                  OP_ROT:       state_d = (ROT_N == 3'd0) ? S_DONE : S_ROT;
                  default:      state_d = S_IDLE;
               endcase
            end
         end
         S_LOAD: begin
            if (!HOLD) begin
               cnt_d   = '0;
               state_d = (op_q == OP_TX) ? S_SHIFT : S_DONE;
            end
         end
         S_SHIFT: begin
            if (!HOLD) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1))
                  state_d = S_DONE;
            end
         end
         S_ROT: begin
            // ROT is only entered with a nonzero count, so the count is reached before wrap.
            if (!HOLD) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == CNT_W'(n_q))
                  state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= 2'b00;
         dir_q   <= 1'b0;
         n_q     <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         dir_q   <= dir_d;
         n_q     <= n_d;
      end
   end

   always_comb begin
      REG_MODO = MODO_LOAD;
      REG_DIR  = 1'b0;
      case (state_q)
         S_SHIFT: begin
            REG_MODO = MODO_PUSH;
            REG_DIR  = dir_q;
         end
         S_ROT: begin
            REG_MODO = MODO_CYCLE;
            REG_DIR  = dir_q;
         end
         default: ;
      endcase
   end

   assign REG_ENB = ((state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_ROT)) && !HOLD;
   assign BUSY    = (state_q != S_IDLE);
   assign DONE    = (state_q == S_DONE);

endmodule

// File: doc/s2p_seq_ctrl.md
Name: s2p_seq_ctrl

Overview:
- Sequencer for the 8-bit serial/parallel shift register (`PUSH`/`CYCLE`/`LOAD` modes from definitions.v).
- Accepts one command per START handshake and drives the register's MODO/ENB/DIR for the exact number of cycles the operation needs.
- Operations:
  - transmit: load, then shift out WIDTH bits.
  - receive: shift in WIDTH bits.
  - rotate: rotate by N.
  - load-only.
- Reports BUSY/DONE to the host FSM.

Parameters:
WIDTH  8  shift length in bits for TX/RX; must equal register width
CNT_W  4  counter width; must satisfy 2^CNT_W > WIDTH

Ports:
CLK       input   1      rising-edge clock
RESET     input   1      synchronous, active-low reset
START     input   1      command request; sampled only in IDLE
OP        input   2      00 TX, 01 RX, 10 ROT, 11 LDONLY; sampled with START
DIR_IN    input   1      shift/rotate direction (0 = toward MSB); sampled with START
ROT_N     input   3      rotate count 0..7; sampled with START
HOLD      input   1      pause: freezes register and sequencer while asserted
REG_MODO  output  2      mode to register (`PUSH`, `CYCLE`, `LOAD`)
REG_ENB   output  1      enable to register
REG_DIR   output  1      direction to register
BUSY      output  1      high in every state except IDLE
DONE      output  1      one-cycle completion pulse

Behaviour:
- Interface decision: one clock, CLK. Reset is synchronous and active-low, named RESET. RESET sampled low at a CLK edge puts the block in IDLE.
- Reset values:
  - state=IDLE, counter=0, latched OP/DIR/N=0.
  - REG_ENB=0, REG_MODO=`LOAD, REG_DIR=0, BUSY=0, DONE=0.
- Reset dominates START and HOLD.
- Reset mid-operation: the block returns to IDLE on that edge. No DONE is issued and the partial operation is abandoned.
- States: IDLE, LOAD, SHIFT, ROT, DONE. State, counter and latched fields are registered.
- REG_ENB is combinational: (state in LOAD/SHIFT/ROT) AND NOT HOLD. All other outputs decode from state only.
- IDLE:
  - REG_ENB=0, REG_MODO=`LOAD.
  - On START=1: latch OP, DIR_IN and ROT_N; clear the counter.
  - Next state by OP:
    - TX or LDONLY goes to LOAD.
    - RX goes to SHIFT.
    - ROT with N≠0 goes to ROT.
    - ROT with N=0 goes directly to DONE.
- LOAD:
  - REG_MODO=`LOAD.
  - On an edge with REG_ENB=1: TX goes to SHIFT (counter=0); LDONLY goes to DONE.
- SHIFT:
  - REG_MODO=`PUSH, REG_DIR=latched DIR.
  - Each edge with REG_ENB=1 increments the counter.
  - On the edge where the counter goes WIDTH-1 → WIDTH, go to DONE. This gives exactly WIDTH PUSH edges.
- ROT:
  - REG_MODO=`CYCLE, REG_DIR=latched DIR.
  - Exactly N enabled edges, then DONE.
- DONE:
  - DONE=1, BUSY=1, REG_ENB=0.
  - Unconditionally return to IDLE on the next edge.
- HOLD=1: counter and state are frozen, REG_ENB=0, MODO/DIR are unchanged. HOLD is ignored in IDLE and DONE.
- START outside IDLE, including in the DONE cycle, is ignored and not queued. OP/DIR_IN/ROT_N changes while BUSY have no effect.
- Latency from START edge (no HOLD):
  - TX: DONE high in cycle WIDTH+2; register active on edges 1..WIDTH+1.
  - RX: DONE in cycle WIDTH+1.
  - ROT: DONE in cycle N+1.
  - LDONLY: DONE in cycle 2.
  - ROT with N=0: DONE in cycle 1.
- Back-to-back commands: minimum spacing is the command latency + 1 cycle (DONE → IDLE → accept).

Test Plan:
- RESET=0 for 2 edges with START=1 → BUSY=0, DONE=0, REG_ENB=0, REG_MODO=`LOAD. Release reset: no operation starts until START is sampled in IDLE.
- TX, DIR_IN=0, with register D=8'hA5, S_IN=0 → one `LOAD` enable cycle, then 8 `PUSH` cycles. Register S_OUT sequence is 1,0,1,0,0,1,0,1. DONE pulses 10 cycles after START; Q=8'h00.
- RX, DIR_IN=1, S_IN stream 1,1,0,0,1,0,1,0 → exactly 8 PUSH edges. DONE in cycle 9; Q=8'h53. START pulsed during SHIFT is ignored.
- ROT, ROT_N=3, DIR_IN=0, Q preloaded 8'h81 → 3 `CYCLE` edges, Q=8'h0C, DONE in cycle 4. ROT_N=0 → DONE in cycle 1 with REG_ENB never asserted.
- TX with HOLD=1 for 3 cycles in mid-SHIFT → REG_ENB=0 during HOLD, Q/S_OUT frozen. Total PUSH edges is still 8; DONE is delayed by exactly 3 cycles.
- RESET=0 asserted during the 5th SHIFT cycle → IDLE on that edge, BUSY=0, no DONE pulse. A new START is then accepted and completes normally.
